decode_stage: RTL and testbench

- Decode stage sitting directly upstream of the Execute stage.
- Takes a 16-bit LC-3-style instruction and its next-PC from Fetch.
- Decodes the instruction into the Execute stage's control_in, imm, register selects and enable_ex pulse.
- Holds a register scoreboard that stalls Fetch on read-after-write hazards until Writeback retires the pending destination.

---
 rtl/decode_stage.sv | 239 +++++++++++++++++++++++
 tb/tb_decode_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Decode stage: turns an LC-3-style instruction into Execute controls and stalls Fetch on RAW hazards
// through a register scoreboard. Optional build macro: DECODE_WB_BYPASS_EN (same-cycle writeback unblocks).
module decode_stage #(
    parameter int DATA_W    = 16,
    parameter int RF_ADDR_W = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable_decode,
    input  logic                 instr_valid,
    input  logic [DATA_W-1:0]    instr_in,
    input  logic [DATA_W-1:0]    npc_in,
    input  logic                 wb_en,
    input  logic [RF_ADDR_W-1:0] wb_dr,
    output logic                 stall,
    output logic                 enable_ex,
    output logic [DATA_W-1:0]    ir,
    output logic [DATA_W-1:0]    npc_out,
    output logic [5:0]           control_in,
    output logic [DATA_W-1:0]    imm,
    output logic [RF_ADDR_W-1:0] sr1,
    output logic [RF_ADDR_W-1:0] sr2,
    output logic [RF_ADDR_W-1:0] dr,
    output logic                 illegal
);

    localparam int NUM_REGS = 1 << RF_ADDR_W;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    typedef enum logic {EMPTY, HELD} stateT;

    stateT                 state, nextState;
    logic [DATA_W-1:0]     holdInstr, holdNpc;
    logic [DATA_W-1:0]     curInstr, curNpc;
    logic [3:0]            opcode;
    logic [RF_ADDR_W-1:0]  curDr, curSr1, curSr2, lowReg;
    logic                  isStore;
    logic [1:0]            aluOp, memOp;
    logic                  op2Imm, lea;
    logic [DATA_W-1:0]     decImm;
    logic                  decWriter, decIllegal;
    logic [NUM_REGS-1:0]   pending, readMask, wbMask, setMask, effPending;
    logic                  hazard, issue, capture;
    logic [DATA_W-1:0]     imm5Ext, off6Ext, off9Ext;

    // A held instruction takes priority over whatever Fetch presents
    assign curInstr = (state == HELD) ? holdInstr : instr_in;
    assign curNpc   = (state == HELD) ? holdNpc   : npc_in;
    assign opcode   = curInstr[DATA_W-1 -: 4];
    assign curDr    = curInstr[11:9];
    assign curSr1   = curInstr[8:6];
    assign lowReg   = curInstr[2:0];
    assign isStore  = (opcode == OP_ST) || (opcode == OP_STR) || (opcode == OP_STI);
    assign curSr2   = isStore ? curDr : lowReg;

    assign imm5Ext = {{(DATA_W-5){curInstr[4]}}, curInstr[4:0]};
    assign off6Ext = {{(DATA_W-6){curInstr[5]}}, curInstr[5:0]};
    assign off9Ext = {{(DATA_W-9){curInstr[8]}}, curInstr[8:0]};

    always_comb begin
        aluOp      = 2'b00;
        op2Imm     = 1'b0;
        memOp      = 2'b00;
        lea        = 1'b0;
        decImm     = '0;
        readMask   = '0;
        decWriter  = 1'b0;
        decIllegal = 1'b0;
        case (opcode)
            OP_ADD, OP_AND: begin
                aluOp            = (opcode == OP_AND) ? 2'b01 : 2'b00;
                op2Imm           = curInstr[5];
                decWriter        = 1'b1;
                readMask[curSr1] = 1'b1;
                if (curInstr[5])
                    decImm = imm5Ext;
                else
                    readMask[lowReg] = 1'b1;
            end
            OP_NOT: begin
                aluOp            = 2'b10;
                decWriter        = 1'b1;
                readMask[curSr1] = 1'b1;
            end
            OP_LD: begin
                memOp     = 2'b01;
                decImm    = off9Ext;
                decWriter = 1'b1;
            end
            OP_LDR: begin
                memOp            = 2'b01;
                decImm           = off6Ext;
                decWriter        = 1'b1;
                readMask[curSr1] = 1'b1;
            end
            OP_LDI: begin
                memOp     = 2'b11;
                decImm    = off9Ext;
                decWriter = 1'b1;
            end
            OP_ST: begin
                memOp            = 2'b10;
                decImm           = off9Ext;
                readMask[curSr2] = 1'b1;
            end
            OP_STR: begin
                memOp            = 2'b10;
                decImm           = off6Ext;
                readMask[curSr1] = 1'b1;
                readMask[curSr2] = 1'b1;
            end
            OP_STI: begin
                memOp            = 2'b11;
                decImm           = off9Ext;
                readMask[curSr2] = 1'b1;
            end
            OP_LEA: begin
                lea       = 1'b1;
                decImm    = off9Ext;
                decWriter = 1'b1;
            end
            OP_BR: begin
                aluOp  = 2'b11;
                decImm = off9Ext;
            end
            OP_JMP: begin
                aluOp            = 2'b11;
                readMask[curSr1] = 1'b1;
            end
            default: decIllegal = 1'b1;
        endcase
    end

    always_comb begin
        wbMask = '0;
        if (wb_en)
            wbMask[wb_dr] = 1'b1;
        setMask = '0;
        if (issue && decWriter)
            setMask[curDr] = 1'b1;
    end

`ifdef DECODE_WB_BYPASS_EN
    assign effPending = pending & ~wbMask;
`else
    assign effPending = pending;
`endif

    assign hazard = |(readMask & effPending);
    assign stall  = (state == HELD);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= EMPTY;
        else
            state <= nextState;
    end

    // Stage enable gates every transition; a low enable simply freezes the FSM
    always_comb begin
        nextState = state;
        issue     = 1'b0;
        capture   = 1'b0;
        if (enable_decode) begin
            case (state)
                EMPTY: begin
                    if (instr_valid) begin
                        if (hazard) begin
                            capture   = 1'b1;
                            nextState = HELD;
                        end else begin
                            issue = 1'b1;
                        end
                    end
                end
                HELD: begin
                    if (!hazard) begin
                        issue     = 1'b1;
                        nextState = EMPTY;
                    end
                end
            endcase
        end
    end

    // Set is ORed in after the clear so a same-index set wins
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending   <= '0;
            holdInstr <= '0;
            holdNpc   <= '0;
        end else begin
            pending <= (pending & ~wbMask) | setMask;
            if (capture) begin
                holdInstr <= instr_in;
                holdNpc   <= npc_in;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            enable_ex  <= 1'b0;
            illegal    <= 1'b0;
            ir         <= '0;
            npc_out    <= '0;
            control_in <= '0;
            imm        <= '0;
            sr1        <= '0;
            sr2        <= '0;
            dr         <= '0;
        end else begin
            enable_ex <= issue;
            illegal   <= issue & decIllegal;
            if (issue) begin
                ir         <= curInstr;
                npc_out    <= curNpc;
                control_in <= {aluOp, op2Imm, memOp, lea};
                imm        <= decImm;
                sr1        <= curSr1;
                sr2        <= curSr2;
                dr         <= curDr;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios followed by randomized traffic
// compared against a cycle-level reference model of issue, hold and scoreboard behaviour.
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable_decode = 1'b0;
    logic        instr_valid = 1'b0;
    logic [15:0] instr_in = '0;
    logic [15:0] npc_in = '0;
    logic        wb_en = 1'b0;
    logic [2:0]  wb_dr = '0;
    logic        stall, enable_ex, illegal;
    logic [15:0] ir, npc_out, imm;
    logic [5:0]  control_in;
    logic [2:0]  sr1, sr2, dr;

    int checkCount = 0;
    int errorCount = 0;

    logic [7:0]  mPending;
    logic        mHeld;
    logic [15:0] mHeldInstr, mHeldNpc;
    logic        mEnEx, mIllegal;
    logic [15:0] mIr, mNpc, mImm;
    logic [5:0]  mCtrl;
    logic [2:0]  mSr1, mSr2, mDr;

    decode_stage #(.DATA_W(16), .RF_ADDR_W(3)) dut (
        .clock(clock), .reset(reset), .enable_decode(enable_decode),
        .instr_valid(instr_valid), .instr_in(instr_in), .npc_in(npc_in),
        .wb_en(wb_en), .wb_dr(wb_dr), .stall(stall), .enable_ex(enable_ex),
        .ir(ir), .npc_out(npc_out), .control_in(control_in), .imm(imm),
        .sr1(sr1), .sr2(sr2), .dr(dr), .illegal(illegal)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [15:0] signExtend(input logic [15:0] ins, input int bits);
        int v;
        v = int'(ins) % (1 << bits);
        if (v >= (1 << (bits - 1)))
            v = v - (1 << bits);
        return v[15:0];
    endfunction

    // Reference decode straight from the opcode table; control = {alu, op2imm, mem, lea}
    function automatic void refDecode(input logic [15:0] ins, output logic [5:0] ctrl,
                                      output logic [15:0] immV, output logic [7:0] reads,
                                      output logic writes, output logic bad, output logic store);
        logic [2:0] fieldA, fieldB, fieldC;
        fieldA = ins[11:9];
        fieldB = ins[8:6];
        fieldC = ins[2:0];
        ctrl = '0; immV = '0; reads = '0; writes = 1'b0; bad = 1'b0; store = 1'b0;
        case (ins[15:12])
            4'h1, 4'h5: begin
                ctrl = {(ins[15:12] == 4'h5) ? 2'b01 : 2'b00, ins[5], 3'b000};
                writes = 1'b1;
                reads[fieldB] = 1'b1;
                if (ins[5]) immV = signExtend(ins, 5);
                else reads[fieldC] = 1'b1;
            end
            4'h9: begin ctrl = 6'b100000; writes = 1'b1; reads[fieldB] = 1'b1; end
            4'h2: begin ctrl = 6'b000010; immV = signExtend(ins, 9); writes = 1'b1; end
            4'h6: begin ctrl = 6'b000010; immV = signExtend(ins, 6); writes = 1'b1; reads[fieldB] = 1'b1; end
            4'hA: begin ctrl = 6'b000110; immV = signExtend(ins, 9); writes = 1'b1; end
            4'h3: begin ctrl = 6'b000100; immV = signExtend(ins, 9); reads[fieldA] = 1'b1; store = 1'b1; end
            4'h7: begin
                ctrl = 6'b000100; immV = signExtend(ins, 6);
                reads[fieldA] = 1'b1; reads[fieldB] = 1'b1; store = 1'b1;
            end
            4'hB: begin ctrl = 6'b000110; immV = signExtend(ins, 9); reads[fieldA] = 1'b1; store = 1'b1; end
            4'hE: begin ctrl = 6'b000001; immV = signExtend(ins, 9); writes = 1'b1; end
            4'h0: begin ctrl = 6'b110000; immV = signExtend(ins, 9); end
            4'hC: begin ctrl = 6'b110000; reads[fieldB] = 1'b1; end
            default: bad = 1'b1;
        endcase
    endfunction

    task automatic resetModel();
        mPending = '0; mHeld = 1'b0; mHeldInstr = '0; mHeldNpc = '0;
        mEnEx = 1'b0; mIllegal = 1'b0; mIr = '0; mNpc = '0; mImm = '0;
        mCtrl = '0; mSr1 = '0; mSr2 = '0; mDr = '0;
    endtask

    task automatic checkAll();
        checkOutput("enable_ex", 32'(enable_ex), 32'(mEnEx));
        checkOutput("illegal", 32'(illegal), 32'(mIllegal));
        checkOutput("stall", 32'(stall), 32'(mHeld));
        checkOutput("ir", 32'(ir), 32'(mIr));
        checkOutput("npc_out", 32'(npc_out), 32'(mNpc));
        checkOutput("control_in", 32'(control_in), 32'(mCtrl));
        checkOutput("imm", 32'(imm), 32'(mImm));
        checkOutput("dr", 32'(dr), 32'(mDr));
        checkOutput("sr1", 32'(sr1), 32'(mSr1));
        checkOutput("sr2", 32'(sr2), 32'(mSr2));
        checkOutput("pending", 32'(dut.pending), 32'(mPending));
    endtask

    // One clock of stimulus: model predicts the post-edge state, then outputs are compared
    task automatic applyStimulus(input logic en, input logic val, input logic [15:0] ins,
                                 input logic [15:0] pc, input logic we, input logic [2:0] wd);
        logic [15:0] src, srcNpc, immV;
        logic [5:0]  ctrl;
        logic [7:0]  reads, effPending;
        logic        writes, bad, store, issue;
        enable_decode = en; instr_valid = val; instr_in = ins; npc_in = pc; wb_en = we; wb_dr = wd;
        checkOutput("stall_pre", 32'(stall), 32'(mHeld));
        src    = mHeld ? mHeldInstr : ins;
        srcNpc = mHeld ? mHeldNpc : pc;
        refDecode(src, ctrl, immV, reads, writes, bad, store);
        effPending = mPending;
`ifdef DECODE_WB_BYPASS_EN
        if (we) effPending[wd] = 1'b0;
`endif
        issue = 1'b0;
        if (en) begin
            if (mHeld) begin
                if ((reads & effPending) == 8'h00) begin
                    issue = 1'b1;
                    mHeld = 1'b0;
                end
            end else if (val) begin
                if ((reads & effPending) != 8'h00) begin
                    mHeld = 1'b1; mHeldInstr = ins; mHeldNpc = pc;
                end else begin
                    issue = 1'b1;
                end
            end
        end
        if (we) mPending[wd] = 1'b0;
        if (issue && writes) mPending[src[11:9]] = 1'b1;
        mEnEx = issue;
        mIllegal = issue && bad;
        if (issue) begin
            mIr = src; mNpc = srcNpc; mCtrl = ctrl; mImm = immV;
            mDr = src[11:9]; mSr1 = src[8:6]; mSr2 = store ? src[11:9] : src[2:0];
        end
        @(posedge clock);
        #1;
        checkAll();
    endtask

    initial begin
        logic        en, val, we;
        logic [2:0]  wd;
        logic [15:0] ins;
        int          start;

        resetModel();
        repeat (2) @(posedge clock);
        #1;
        checkAll();
        reset = 1'b1;

        applyStimulus(1'b1, 1'b1, 16'h1263, 16'h0001, 1'b0, 3'd0);
        checkOutput("tp_add_en", 32'(enable_ex), 32'd1);
        checkOutput("tp_add_dr", 32'(dr), 32'd1);
        checkOutput("tp_add_sr2", 32'(sr2), 32'd3);
        checkOutput("tp_add_pend1", 32'(dut.pending[1]), 32'd1);

        applyStimulus(1'b1, 1'b1, 16'h147F, 16'h0002, 1'b0, 3'd0);
        checkOutput("tp_raw_stall", 32'(stall), 32'd1);
        applyStimulus(1'b1, 1'b1, 16'h0000, 16'h0003, 1'b1, 3'd1);
        applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0003, 1'b0, 3'd0);
        checkOutput("tp_raw_imm", 32'(imm), 32'hFFFF);
        checkOutput("tp_raw_ctrl", 32'(control_in), 32'b001000);

        applyStimulus(1'b1, 1'b1, 16'h6960, 16'h0004, 1'b0, 3'd0);
        checkOutput("tp_ldr_ctrl", 32'(control_in), 32'b000010);
        checkOutput("tp_ldr_imm", 32'(imm), 32'hFFE0);
        checkOutput("tp_ldr_pend4", 32'(dut.pending[4]), 32'd1);

        applyStimulus(1'b1, 1'b1, 16'hD000, 16'h0005, 1'b0, 3'd0);
        checkOutput("tp_ill_flag", 32'(illegal), 32'd1);
        checkOutput("tp_ill_ctrl", 32'(control_in), 32'd0);

        applyStimulus(1'b1, 1'b1, 16'h1704, 16'h0006, 1'b0, 3'd0);
        applyStimulus(1'b0, 1'b1, 16'h1704, 16'h0006, 1'b1, 3'd4);
        applyStimulus(1'b0, 1'b1, 16'h1704, 16'h0006, 1'b0, 3'd0);
        applyStimulus(1'b0, 1'b1, 16'h1704, 16'h0006, 1'b0, 3'd0);
        checkOutput("tp_dis_stall", 32'(stall), 32'd1);
        applyStimulus(1'b1, 1'b1, 16'h1704, 16'h0006, 1'b0, 3'd0);
        checkOutput("tp_reen_issue", 32'(enable_ex), 32'd1);
        checkOutput("tp_reen_stall", 32'(stall), 32'd0);

        applyStimulus(1'b1, 1'b1, 16'h1AC3, 16'h0007, 1'b0, 3'd0);
        checkOutput("tp_held_again", 32'(stall), 32'd1);
        #3;
        reset = 1'b0;
        instr_valid = 1'b0;
        #1;
        resetModel();
        checkAll();
        #2;
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 16'h1263, 16'h0010, 1'b0, 3'd0);
        checkOutput("tp_post_rst_en", 32'(enable_ex), 32'd1);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            en  = ($urandom_range(0, 9) != 0);
            val = ($urandom_range(0, 3) != 0);
            ins = {4'($urandom_range(0, 15)), 12'($urandom)};
            we  = 1'b0;
            wd  = 3'($urandom_range(0, 7));
            if (mPending != 8'h00 && $urandom_range(0, 2) == 0) begin
                start = $urandom_range(0, 7);
                for (int k = 0; k < 8; k++) begin
                    if (!we && mPending[(start + k) % 8]) begin
                        we = 1'b1;
                        wd = 3'((start + k) % 8);
                    end
                end
            end else if ($urandom_range(0, 9) == 0) begin
                we = 1'b1;
            end
            applyStimulus(en, val, ins, 16'($urandom), we, wd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
